// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter for four requesters sharing a 4:1 mux.
//               Grants one requester at a time, drives the mux select with
//               the owner's index. Optional hold-limit preemption is built
//               when the macro MUX4_ARB_HOLD_LIMIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] s,
   output logic       busy,
   output logic       preempt
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [1:0]        ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic [3:0]        owner_mask;
   logic [3:0]        others;
   logic              owner_req;
   logic              timeout;
   logic [2:0]        pick_all;
   logic [2:0]        pick_oth;

   logic              do_grant;
   logic              do_drop;
   logic              do_pre;
   logic [1:0]        grant_idx;

   // First set bit of v searching upward from p with wrap; {found, index}.
   function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
      logic       found;
      logic [1:0] idx;
      logic [1:0] cand;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         cand = p + i[1:0];
         if (!found && v[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   // In GRANT the select register names the owner, so its mask comes from s.
   assign owner_mask = 4'b0001 << s;
   assign others     = req & ~owner_mask;
   assign owner_req  = |(req & owner_mask);
   assign pick_all   = rr_pick(req, ptr);
   assign pick_oth   = rr_pick(others, ptr);

`ifdef MUX4_ARB_HOLD_LIMIT_EN
   // Owner has used its full allowance and someone else is waiting.
   assign timeout = (hold_cnt == HOLD_MAX) && (|others);
`else
   assign timeout = 1'b0;
`endif

   // State register plus the registered grant/select/pointer datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         s        <= 2'd0;
         ptr      <= 2'd0;
         hold_cnt <= '0;
         preempt  <= 1'b0;
      end else begin
         state   <= state_nxt;
         preempt <= do_pre;
         if (do_grant) begin
            gnt      <= 4'b0001 << grant_idx;
            s        <= grant_idx;
            ptr      <= grant_idx + 2'd1;
            hold_cnt <= '0;
         end else if (do_drop) begin
            gnt      <= 4'b0000;
            hold_cnt <= '0;
         end else if ((state == GRANT) && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   // Next-state and grant decision: new grant, release handoff, or timeout.
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_drop   = 1'b0;
      do_pre    = 1'b0;
      grant_idx = 2'd0;
      case (state)
         IDLE: begin
            if (pick_all[2]) begin
               do_grant  = 1'b1;
               grant_idx = pick_all[1:0];
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               // Release wins over a coincident timeout; no preempt pulse.
               if (pick_oth[2]) begin
                  do_grant  = 1'b1;
                  grant_idx = pick_oth[1:0];
               end else begin
                  do_drop   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (timeout) begin
               do_grant  = 1'b1;
               do_pre    = 1'b1;
               grant_idx = pick_oth[1:0];
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Busy simply reflects a live grant.
   always_comb begin
      busy = |gnt;
   end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Self-checking bench for mux4_rr_arbiter: directed vector
//               table, hold-limit sequences and randomized traffic against
//               a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

   localparam int MAXH = 4;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
   localparam bit HL = 1'b1;
`else
   localparam bit HL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] s;
   logic       busy;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   // Behavioural model state: owner index (-1 idle), pointer, hold count.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   int m_s     = 0;
   bit m_pre   = 1'b0;

   mux4_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .s       (s),
      .busy    (busy),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] s;
      bit         busy;
   } vec_t;

   vec_t tbl[20];

   function automatic int first_from(logic [3:0] v, int p);
      for (int i = 0; i < 4; i++) begin
         int k;
         k = (p + i) % 4;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_give(int w);
      m_owner = w;
      m_s     = w;
      m_ptr   = (w + 1) % 4;
      m_hold  = 0;
   endtask

   task automatic model_step(bit r, logic [3:0] q);
      logic [3:0] oth;
      int w;
      if (r) begin
         m_owner = -1; m_s = 0; m_ptr = 0; m_hold = 0; m_pre = 1'b0;
         return;
      end
      m_pre = 1'b0;
      if (m_owner < 0) begin
         w = first_from(q, m_ptr);
         if (w >= 0) model_give(w);
      end else begin
         oth = q;
         oth[m_owner] = 1'b0;
         if (!q[m_owner]) begin
            w = first_from(oth, m_ptr);
            if (w >= 0) model_give(w);
            else begin m_owner = -1; m_hold = 0; end
         end else if (HL && (m_hold == MAXH - 1) && (oth != 4'b0000)) begin
            model_give(first_from(oth, m_ptr));
            m_pre = 1'b1;
         end else if (m_hold < MAXH - 1) begin
            m_hold++;
         end
      end
   endtask

   task automatic tick(bit r, logic [3:0] q);
      rst = r;
      req = q;
      @(posedge clk);
      model_step(r, q);
      #1;
   endtask

   task automatic check(string name, logic [3:0] eg, logic [1:0] es, logic eb, logic ep);
      checks++;
      if (gnt !== eg || s !== es || busy !== eb || preempt !== ep) begin
         errors++;
         $display("FAIL %s: got gnt=%b s=%0d busy=%b preempt=%b, expected gnt=%b s=%0d busy=%b preempt=%b",
                  name, gnt, s, busy, preempt, eg, es, eb, ep);
      end
   endtask

   task automatic check_model(string name);
      logic [3:0] eg;
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      check(name, eg, 2'(m_s), (m_owner >= 0), m_pre);
      checks++;
      if (!$onehot0(gnt)) begin
         errors++;
         $display("FAIL onehot_%s: got gnt=%b, expected one-hot or zero", name, gnt);
      end
   endtask

   initial begin
      logic [3:0] r;
      bit         rr;

      // rst, req, expected gnt, s, busy (values reached after that edge)
      tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};  // reset held
      tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};  // first grant after reset
      tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};  // one-cycle grant
      tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};  // single requester
      tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};  // s holds while idle
      tbl[6]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};  // ptr=3 wraps to 0
      tbl[7]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};  // release hands to 1
      tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};
      tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};  // reset before rotation
      tbl[10] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};  // rotation 0,1,2,3,0
      tbl[11] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
      tbl[12] = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1};
      tbl[13] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1};
      tbl[14] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
      tbl[15] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[16] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};  // owner 3
      tbl[17] = '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0};  // mid-grant reset
      tbl[18] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};  // regrant from ptr 0
      tbl[19] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0};

      for (int i = 0; i < 20; i++) begin
         tick(tbl[i].rst, tbl[i].req);
         check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].s, tbl[i].busy, 1'b0);
      end

      // Constant contention from 0 and 1 for 50 cycles.
      tick(1'b1, 4'b0000);
      for (int c = 0; c < 50; c++) begin
         tick(1'b0, 4'b0011);
         if (HL)
            check($sformatf("hold_c%0d", c),
                  (((c / MAXH) % 2) == 0) ? 4'b0001 : 4'b0010,
                  (((c / MAXH) % 2) == 0) ? 2'd0 : 2'd1,
                  1'b1, (c >= MAXH) && ((c % MAXH) == 0));
         else
            check($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
      end

      // Release on the same edge the timeout would fire: plain handoff.
      tick(1'b1, 4'b0000);
      for (int c = 0; c < MAXH; c++) begin
         tick(1'b0, 4'b0011);
         check($sformatf("relto_hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      tick(1'b0, 4'b0010);
      check("relto_release", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Randomized traffic against the model.
      tick(1'b1, 4'b0000);
      r = 4'b0000;
      for (int n = 0; n < 600; n++) begin
         rr = ($urandom_range(0, 63) == 0);
         case ($urandom_range(0, 7))
            0, 1:    r = 4'($urandom);
            2:       if (m_owner >= 0) r[m_owner] = 1'b0;
            3:       r[$urandom_range(0, 3)] ^= 1'b1;
            default: ;
         endcase
         tick(rr, r);
         check_model($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares the team's 4:1 select-driven mux datapath between four requesters. It samples a 4-bit request vector and grants exactly one requester at a time. It drives the mux select with the owner's index so that requester's input reaches the shared output. An optional hold-limit timer preempts a requester that keeps its grant too long while others are waiting.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles before preemption (legal range 2..15; used only with the optional feature)
HOLD_W, 4, width of the hold counter; must hold MAX_HOLD-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request vector; req[k] high = requester k wants the mux
gnt  output 4  one-hot grant, registered; all-zero when idle
s    output 2  mux select = binary index of current owner; drives the 4:1 mux select
busy output 1  high whenever gnt is non-zero
preempt output 1  one-cycle pulse: the grant was taken by timeout (0 when feature compiled out)

Behaviour:
- Reset (rst=1 at clock edge): gnt=0, s=0, busy=0, preempt=0, round-robin pointer ptr=0, hold_cnt=0, state IDLE. Takes priority over all other inputs, including mid-grant.
- Search order: starting at ptr, ascending, wrapping 3->0. The first index with req set wins.
- State machine has two states: IDLE and GRANT.
- IDLE:
  - If req != 0 at an edge, the winner k is granted in the next cycle (1-cycle latency).
  - On grant: gnt=1<<k, s=k, busy=1, ptr=(k+1) mod 4, hold_cnt=0, go to GRANT.
  - If req == 0, stay IDLE.
- GRANT, owner o:
  - While req[o]=1: grant is held and hold_cnt increments each cycle, saturating at MAX_HOLD-1.
  - Release: when req[o]=0 at an edge, re-arbitrate in that same edge over req with bit o masked, starting at ptr. A winner j gets the grant on the next cycle, with no idle bubble, and hold_cnt=0, ptr=(j+1) mod 4. If there is no winner, gnt=0, busy=0, and the state returns to IDLE.
- s holds its last value while idle; it changes only on a new grant or reset.
- gnt is always one-hot or zero, and never changes except at a grant, release, preempt, or reset edge.
- Widths: ptr is 2 bits with natural wrap; hold_cnt is HOLD_W bits, saturating, never wrapping.
- Simultaneous events:
  - Release and timeout at the same edge: treated as a release; preempt stays 0.
  - A requester dropping req the cycle after its grant: its grant lasts exactly one cycle.
  - All four requesting continuously with no release: grants rotate only via timeout. Without the feature, the owner holds indefinitely.

Optional Feature:
Macro: MUX4_ARB_HOLD_LIMIT_EN
- Defined:
  - In GRANT, if hold_cnt==MAX_HOLD-1, req[o]=1, and any other req bit is set, the next cycle grants the next other requester found from ptr.
  - preempt=1 for that one cycle and hold_cnt=0.
  - If no other requester is waiting, the owner keeps the grant and hold_cnt stays saturated.
  - The owner therefore holds at most MAX_HOLD cycles under contention.
- Undefined: no preemption logic is built, preempt is tied to 0, and the grant is held until the owner releases.

Test Plan:
- Reset check: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, s=0, busy=0, preempt=0. First cycle after reset release, req=4'b1111 -> gnt=4'b0001, s=0.
- Single requester: req=4'b0100 sampled at edge N -> gnt=4'b0100, s=2, busy=1 from cycle N+1. Drop req -> gnt=0, busy=0 next cycle, s stays 2.
- Rotation: req=4'b1111, each owner holds 1 cycle then toggles its bit low for one edge -> grant order 0,1,2,3,0 with s=0,1,2,3,0 and no idle cycles.
- Wrap and skip: ptr=3 (after granting 2), req=4'b0011 -> gnt=4'b0001, then on release gnt=4'b0010.
- Timeout (macro defined, MAX_HOLD=4): req=4'b0011 held constant -> gnt=0001 for exactly 4 cycles, then 0010 with preempt=1 for one cycle, then alternate every 4 cycles. Macro undefined -> gnt stays 0001 for 50 cycles and preempt stays 0.
- Mid-grant reset: owner 3 granted, rst=1 for one edge -> gnt=0 next cycle. With req=4'b1000 still high -> gnt=4'b1000 one cycle after rst falls (ptr restarted at 0).
